// File: rtl/reaction_seq_fsm.sv
// Reaction-timer light sequencer: fills N LEDs one per tick, waits for the random delay, then times the player.
// Optional build macro FAULT_BLINK_EN: LEDs blink on each tick while in FAULT instead of staying dark.
//
// state   | meaning
// IDLE    | waiting for trigger, lights off
// FILL    | lighting LEDs one per tick
// DELAY   | all lit, random delay running
// MEASURE | lights out, counting reaction ticks
// DONE    | one-cycle result strobe
// FAULT   | false start, waiting for trigger to re-arm
module reaction_seq_fsm #(
  parameter int N_LEDS   = 10,
  parameter int RT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                trigger,
  input  logic                time_out,
  input  logic                response,
  output logic                en_lfsr,
  output logic                start_delay,
  output logic [N_LEDS-1:0]   ledr,
  output logic [RT_WIDTH-1:0] rt_count,
  output logic                rt_valid,
  output logic                false_start,
  output logic                busy
);

  localparam int IW = $clog2(N_LEDS + 1);
  localparam logic [IW-1:0]       IDX_FULL     = IW'(N_LEDS);
  localparam logic [IW-1:0]       IDX_LFSR_MAX = IW'(N_LEDS - 2);
  localparam logic [IW-1:0]       IDX_ONE      = IW'(1);
  localparam logic [RT_WIDTH-1:0] RT_MAX       = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DELAY,
    S_MEASURE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;

  assign idx_nxt = idx + IDX_ONE;

  function automatic logic [N_LEDS-1:0] thermo(input logic [IW-1:0] n);
    logic [N_LEDS-1:0] t;
    for (int k = 0; k < N_LEDS; k++) t[k] = (k < int'(n));
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      ledr        <= '0;
      en_lfsr     <= 1'b0;
      start_delay <= 1'b0;
      rt_count    <= '0;
      rt_valid    <= 1'b0;
      false_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state    <= S_FILL;
            idx      <= IDX_ONE;
            ledr     <= thermo(IDX_ONE);
            en_lfsr  <= (IDX_ONE <= IDX_LFSR_MAX);
            rt_count <= '0;
            busy     <= 1'b1;
          end
        end

        // A press before lights-out wins over any simultaneous tick or time_out.
        S_FILL, S_DELAY: begin
          if (response) begin
            state       <= S_FAULT;
            idx         <= '0;
            false_start <= 1'b1;
            en_lfsr     <= 1'b0;
            start_delay <= 1'b0;
            busy        <= 1'b0;
`ifdef FAULT_BLINK_EN
            ledr        <= '1;
`else
            ledr        <= '0;
`endif
          end else if (state == S_FILL) begin
            if (tick) begin
              if (idx == IDX_FULL) begin
                state       <= S_DELAY;
                ledr        <= '1;
                en_lfsr     <= 1'b0;
                start_delay <= 1'b1;
              end else begin
                idx     <= idx_nxt;
                ledr    <= thermo(idx_nxt);
                en_lfsr <= (idx_nxt <= IDX_LFSR_MAX);
              end
            end
          end else if (time_out) begin
            state       <= S_MEASURE;
            idx         <= '0;
            ledr        <= '0;
            start_delay <= 1'b0;
          end
        end

        S_MEASURE: begin
          if (response) begin
            state    <= S_DONE;
            rt_valid <= 1'b1;
          end else if (tick && (rt_count != RT_MAX)) begin
            rt_count <= rt_count + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_FAULT: begin
          if (trigger) begin
            state       <= S_IDLE;
            false_start <= 1'b0;
            ledr        <= '0;
          end
`ifdef FAULT_BLINK_EN
          else if (tick) begin
            ledr <= ~ledr;
          end
`endif
        end

        default: begin
          state       <= S_IDLE;
          idx         <= '0;
          ledr        <= '0;
          en_lfsr     <= 1'b0;
          start_delay <= 1'b0;
          false_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_seq_fsm.sv
// Scoreboard bench for reaction_seq_fsm: a 10-LED/16-bit unit and a 3-LED/4-bit unit driven by random game rounds.
module tb_reaction_seq_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic tk[2], tr[2], to[2], rs[2];

  logic        en0, sd0, rv0, fs0, bz0;
  logic [9:0]  ledr0;
  logic [15:0] rt0;
  logic        en1, sd1, rv1, fs1, bz1;
  logic [2:0]  ledr1;
  logic [3:0]  rt1;

  reaction_seq_fsm #(.N_LEDS(10), .RT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tk[0]), .trigger(tr[0]), .time_out(to[0]),
    .response(rs[0]), .en_lfsr(en0), .start_delay(sd0), .ledr(ledr0),
    .rt_count(rt0), .rt_valid(rv0), .false_start(fs0), .busy(bz0));

  reaction_seq_fsm #(.N_LEDS(3), .RT_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tk[1]), .trigger(tr[1]), .time_out(to[1]),
    .response(rs[1]), .en_lfsr(en1), .start_delay(sd1), .ledr(ledr1),
    .rt_count(rt1), .rt_valid(rv1), .false_start(fs1), .busy(bz1));

  int n_checks = 0;
  int n_pass   = 0;
  int q0[$];
  int q1[$];
  bit fsp0 = 1'b0, fsp1 = 1'b0;

  // Expected events per unit: reaction time in ticks, or -1 for a false start.
  function automatic int nl(int u);     return (u == 0) ? 10 : 3;        endfunction
  function automatic int rtmax(int u);  return (u == 0) ? 65535 : 15;    endfunction
  function automatic longint led(int u); return (u == 0) ? longint'(ledr0) : longint'(ledr1); endfunction
  function automatic longint rt(int u);  return (u == 0) ? longint'(rt0) : longint'(rt1);     endfunction
  function automatic bit en(int u);     return (u == 0) ? en0 : en1;     endfunction
  function automatic bit sd(int u);     return (u == 0) ? sd0 : sd1;     endfunction
  function automatic bit fs(int u);     return (u == 0) ? fs0 : fs1;     endfunction
  function automatic bit bz(int u);     return (u == 0) ? bz0 : bz1;     endfunction
  function automatic bit rv(int u);     return (u == 0) ? rv0 : rv1;     endfunction

  task automatic chk(string nm, int u, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s unit%0d: got %0d expected %0d at %0t", nm, u, act, exp, $time);
  endtask

  task automatic push(int u, int e);
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic expect_event(int u, int act, string nm);
    int e;
    n_checks++;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      $display("FAIL %s unit%0d: got %0d with no event expected at %0t", nm, u, act, $time);
    end else begin
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      if (e == act) n_pass++;
      else $display("FAIL %s unit%0d: got %0d expected %0d at %0t", nm, u, act, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rv0) expect_event(0, int'(rt0), "rt_result");
    if (rv1) expect_event(1, int'(rt1), "rt_result");
    if (fs0 && !fsp0) expect_event(0, -1, "false_start_event");
    if (fs1 && !fsp1) expect_event(1, -1, "false_start_event");
    fsp0 = fs0;
    fsp1 = fs1;
  end

  // One clock with the given inputs held for that edge.
  task automatic step(int u, bit t_k, bit t_r, bit t_o, bit r_s);
    tk[u] = t_k; tr[u] = t_r; to[u] = t_o; rs[u] = r_s;
    @(posedge clk);
    #1;
    tk[u] = 1'b0; tr[u] = 1'b0; to[u] = 1'b0; rs[u] = 1'b0;
  endtask

  task automatic fault(int u);
    bit on = 1'b1;
    bit t;
    longint all = (longint'(1) << nl(u)) - 1;
    chk("fault_flag", u, fs(u), 1);
    chk("fault_start_delay", u, sd(u), 0);
    chk("fault_en_lfsr", u, en(u), 0);
    chk("fault_busy", u, bz(u), 0);
    repeat ($urandom_range(1, 4)) begin
`ifdef FAULT_BLINK_EN
      chk("fault_ledr", u, led(u), on ? all : 0);
`else
      chk("fault_ledr", u, led(u), 0);
`endif
      t = 1'($urandom % 2);
      step(u, t, 0, 0, 0);
      if (t) on = ~on;
    end
    step(u, 0, 1, 0, 0);
    chk("fault_rearm_flag", u, fs(u), 0);
    chk("fault_rearm_ledr", u, led(u), 0);
    chk("fault_rearm_busy", u, bz(u), 0);
  endtask

  // mode: 0 normal, 1 false start in fill, 2 false start in delay,
  //       3 response+time_out collision, 4 response+tick collision in measure
  task automatic round(int u, int mode, int nt);
    int n = nl(u);
    int fsi = $urandom_range(1, n);
    int exp_rt;
    step(u, 0, 0, 0, 1);
    chk("idle_ignores_response", u, fs(u) | bz(u), 0);
    step(u, 0, 1, 0, 0);
    chk("trigger_busy", u, bz(u), 1);
    chk("trigger_clears_rt", u, rt(u), 0);
    for (int i = 1; i <= n; i++) begin
      chk("fill_ledr", u, led(u), (longint'(1) << i) - 1);
      chk("fill_en_lfsr", u, en(u), (i <= n - 2) ? 1 : 0);
      repeat ($urandom_range(0, 2)) step(u, 0, 1'($urandom % 4 == 0), 0, 0);
      if (mode == 1 && i == fsi) begin
        push(u, -1);
        step(u, 1, 0, 0, 1);
        fault(u);
        return;
      end
      step(u, 1, 0, 0, 0);
    end
    chk("delay_ledr", u, led(u), (longint'(1) << n) - 1);
    chk("delay_start", u, sd(u), 1);
    chk("delay_en_lfsr", u, en(u), 0);
    repeat ($urandom_range(0, 4)) step(u, 1'($urandom % 2), 0, 0, 0);
    chk("delay_start_held", u, sd(u), 1);
    if (mode == 2 || mode == 3) begin
      push(u, -1);
      step(u, 0, 0, (mode == 3), 1);
      fault(u);
      return;
    end
    step(u, 0, 0, 1, 0);
    chk("lights_out_ledr", u, led(u), 0);
    chk("lights_out_start", u, sd(u), 0);
    for (int k = 0; k < nt; k++) begin
      if ($urandom % 2 == 0) step(u, 0, 1'($urandom % 2), 0, 0);
      step(u, 1, 0, 0, 0);
    end
    exp_rt = (nt > rtmax(u)) ? rtmax(u) : nt;
    push(u, exp_rt);
    step(u, (mode == 4), 0, 0, 1);
    chk("done_strobe", u, rv(u), 1);
    chk("done_busy", u, bz(u), 1);
    step(u, 0, 0, 0, 0);
    chk("idle_busy", u, bz(u), 0);
    chk("idle_rt_hold", u, rt(u), exp_rt);
    chk("idle_strobe_gone", u, rv(u), 0);
  endtask

  task automatic check_all_zero(string nm);
    chk({nm, "_ledr"}, 0, ledr0, 0);  chk({nm, "_ledr"}, 1, ledr1, 0);
    chk({nm, "_rt"}, 0, rt0, 0);      chk({nm, "_rt"}, 1, rt1, 0);
    chk({nm, "_ctl"}, 0, {en0, sd0, rv0, fs0, bz0}, 0);
    chk({nm, "_ctl"}, 1, {en1, sd1, rv1, fs1, bz1}, 0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      tk[u] = 1'b0; tr[u] = 1'b0; to[u] = 1'b0; rs[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    round(0, 0, 237);
    round(0, 1, 0);
    round(0, 2, 0);
    round(0, 3, 0);
    round(0, 4, 5);
    round(1, 0, 20);
    round(1, 4, 3);
    round(1, 1, 0);
    repeat (14) round(int'($urandom % 2), int'($urandom % 5), int'($urandom_range(0, 40)));

    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("pre_abort_ledr", 0, ledr0, 10'h00F);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    round(0, 0, 7);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 0, q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
